// File: rtl/cpu_pkg.sv
// Shared CPU/loader definitions: loader state encoding and word/address step constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_STEP  = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;

endpackage

// File: rtl/byte_to_word.sv
// Big-endian byte-to-word assembler; word_valid pulses the cycle after the 4th accepted byte.
module byte_to_word
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              last_byte_c
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]         cnt;
  logic [WORD_W-BYTE_W-1:0] sr;

  assign last_byte_c = (cnt == CNT_W'(WORD_BYTES - 1));

  // Shift register plus wrapping byte counter; the finished word is latched so it
  // stays stable while the next word starts shifting in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
        sr  <= '0;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
        sr  <= {sr[WORD_W-2*BYTE_W-1:0], in_byte};
        if (last_byte_c) begin
          word       <= {sr, in_byte};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length header, big-endian words, optional XOR checksum
// (enabled by defining IMEM_LOADER_CHECKSUM_EN). Holds the CPU until DONE.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int unsigned LEN_W = 16;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FINAL = CHK;
`else
  localparam state_t FINAL = DONE;
`endif

  state_t           state, state_n;
  logic             tail, tail_n;
  logic             restart;
  logic             ready_n;
  logic             accept;
  logic             data_accept;
  logic             last_byte_c;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_word;

  assign accept      = in_valid & in_ready;
  assign data_accept = accept && (state == DATA);
  assign len_word    = {len[LEN_W-1:BYTE_W], in_data};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over data bytes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            csum <= '0;
    else if (restart)     csum <= '0;
    else if (data_accept) csum <= csum ^ in_data;
  end
`endif

  byte_to_word u_b2w (
    .clk         (clk),
    .reset       (reset),
    .clear       (restart),
    .accept      (data_accept),
    .in_byte     (in_data),
    .word        (im_wdata),
    .word_valid  (im_we),
    .last_byte_c (last_byte_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // tail marks that the final data byte is in; DATA is left once its write pulse is out,
  // and no further bytes are taken in between.
  always_comb begin
    state_n = state;
    tail_n  = tail;
    restart = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n = LEN_HI;
          tail_n  = 1'b0;
          restart = 1'b1;
        end
      end
      LEN_HI: if (accept) state_n = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_word == '0)                  state_n = FINAL;
          else if (32'(len_word) > MAX_WORDS)  state_n = ERR;
          else                                 state_n = DATA;
        end
      end
      DATA: begin
        if (data_accept && last_byte_c && ((words_loaded + 16'd1) == len)) tail_n = 1'b1;
        if (tail && im_we) state_n = FINAL;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (accept) state_n = (in_data == csum) ? DONE : ERR;
`endif
      default: state_n = IDLE;
    endcase
  end

  assign ready_n = (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == CHK) ||
                   ((state_n == DATA) && !tail_n);

  // Registered status, header capture and write address/count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail         <= 1'b0;
      len          <= '0;
      im_addr      <= BASE_ADDR;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      tail     <= tail_n;
      in_ready <= ready_n;
      cpu_hold <= (state_n != DONE);
      done     <= (state_n == DONE);
      error    <= (state_n == ERR);
      if (accept && (state == LEN_HI)) len[LEN_W-1:BYTE_W] <= in_data;
      if (accept && (state == LEN_LO)) len[BYTE_W-1:0]     <= in_data;
      if (restart) begin
        im_addr      <= BASE_ADDR;
        words_loaded <= '0;
      end else if (im_we) begin
        im_addr      <= im_addr + ADDR_W'(ADDR_STEP);
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (MAX_WORDS = 4); checksum scenarios follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, im_we, cpu_hold, done, error;
  logic [31:0] im_addr, im_wdata;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;
  int inv_bad = 0;
  logic [63:0] wq[$];

  imem_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write log plus the cpu_hold/done coupling, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we === 1'b1) wq.push_back({im_addr, im_wdata});
    if (!reset && (cpu_hold !== ~done)) inv_bad++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      bad++; total++;
      $display("FAIL send_timeout byte=%0h in_ready=%0b want=1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_cpu_hold got=%0b want=1", cpu_hold); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%0b want=0", error); end
    total++; if (im_we !== 1'b0) begin bad++; $display("FAIL rst_im_we got=%0b want=0", im_we); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b want=0", in_ready); end
    total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL rst_im_addr got=%0h want=0", im_addr); end
    total++; if (im_wdata !== 32'h0) begin bad++; $display("FAIL rst_im_wdata got=%0h want=0", im_wdata); end
    total++; if (words_loaded !== 16'h0) begin bad++; $display("FAIL rst_words got=%0d want=0", words_loaded); end
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%0b want=0", in_ready); end
    total++; if (wq.size() != 0) begin bad++; $display("FAIL idle_writes got=%0d want=0", wq.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_normal();
    int n0 = wq.size();
    logic [63:0] g0, g1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01);
    start = 1'b1; send_byte(8'h00); start = 1'b0;
    send_byte(8'h05);
    send_byte(8'h8C); send_byte(8'h22); send_byte(8'h00); send_byte(8'h04);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h20 ^ 8'h01 ^ 8'h00 ^ 8'h05 ^ 8'h8C ^ 8'h22 ^ 8'h00 ^ 8'h04);
`endif
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    g0 = (wq.size() > n0) ? wq[n0] : '1;
    g1 = (wq.size() > n0 + 1) ? wq[n0 + 1] : '1;
    total++; if (wq.size() - n0 != 2) begin bad++; $display("FAIL norm_count got=%0d want=2", wq.size() - n0); end
    total++; if (g0 !== {32'h0, 32'h20010005}) begin bad++; $display("FAIL norm_w0 got=%0h want=0_20010005", g0); end
    total++; if (g1 !== {32'h4, 32'h8C220004}) begin bad++; $display("FAIL norm_w1 got=%0h want=4_8c220004", g1); end
    total++; if (words_loaded !== 16'd2) begin bad++; $display("FAIL norm_words got=%0d want=2", words_loaded); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL norm_done got=%0b want=1", done); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL norm_cpu_hold got=%0b want=0", cpu_hold); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL norm_error got=%0b want=0", error); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL norm_in_ready got=%0b want=0", in_ready); end
    total++; if (im_addr !== 32'h8) begin bad++; $display("FAIL norm_addr got=%0h want=8", im_addr); end
  endtask

  task automatic test_empty();
    int n0 = wq.size();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    total++; if (wq.size() != n0) begin bad++; $display("FAIL empty_writes got=%0d want=%0d", wq.size(), n0); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done got=%0b want=1", done); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL empty_words got=%0d want=0", words_loaded); end
    total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL empty_addr got=%0h want=0", im_addr); end
  endtask

  task automatic test_oversize();
    int n0 = wq.size();
    logic [63:0] g0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h05);
    for (int i = 0; i < 20 && error !== 1'b1; i++) @(negedge clk);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL over_error got=%0b want=1", error); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL over_done got=%0b want=0", done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL over_cpu_hold got=%0b want=1", cpu_hold); end
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL over_in_ready got=%0b want=0", in_ready); end
    total++; if (wq.size() != n0) begin bad++; $display("FAIL over_writes got=%0d want=%0d", wq.size(), n0); end
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    g0 = (wq.size() > n0) ? wq[n0] : '1;
    total++; if (g0 !== {32'h0, 32'hDEADBEEF}) begin bad++; $display("FAIL recov_w0 got=%0h want=0_deadbeef", g0); end
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL recov_status got=%0b%0b want=10", done, error); end
  endtask

  task automatic test_gapped();
    int n0 = wq.size();
    logic [63:0] g0;
    logic [7:0] bytes [3];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int k = 0; k < 3; k++) begin
      send_byte(bytes[k]);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    total++; if (wq.size() != n0) begin bad++; $display("FAIL gap_early_write got=%0d want=%0d", wq.size(), n0); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL gap_in_ready got=%0b want=1", in_ready); end
    send_byte(8'h78);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    g0 = (wq.size() > n0) ? wq[n0] : '1;
    total++; if (wq.size() - n0 != 1) begin bad++; $display("FAIL gap_count got=%0d want=1", wq.size() - n0); end
    total++; if (g0 !== {32'h0, 32'h12345678}) begin bad++; $display("FAIL gap_w0 got=%0h want=0_12345678", g0); end
  endtask

  task automatic test_reset_mid();
    int n1;
    logic [63:0] g0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    total++; if (im_addr !== 32'h4 || words_loaded !== 16'd1) begin bad++; $display("FAIL mid_pre got=%0h/%0d want=4/1", im_addr, words_loaded); end
    #2 reset = 1'b1;
    #1;
    n1 = wq.size();
    total++; if (im_addr !== 32'h0) begin bad++; $display("FAIL mid_addr got=%0h want=0", im_addr); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL mid_words got=%0d want=0", words_loaded); end
    total++; if (in_ready !== 1'b0 || im_we !== 1'b0) begin bad++; $display("FAIL mid_ready_we got=%0b%0b want=00", in_ready, im_we); end
    total++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mid_hold_done got=%0b%0b want=10", cpu_hold, done); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wq.size() != n1) begin bad++; $display("FAIL mid_writes got=%0d want=%0d", wq.size(), n1); end
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    g0 = (wq.size() > n1) ? wq[n1] : '1;
    total++; if (g0 !== {32'h0, 32'hAABBCCDD}) begin bad++; $display("FAIL mid_reload got=%0h want=0_aabbccdd", g0); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_done got=%0b want=1", done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    int n0 = wq.size();
    logic [63:0] g0;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 20 && error !== 1'b1; i++) @(negedge clk);
    g0 = (wq.size() > n0) ? wq[n0] : '1;
    total++; if (g0 !== {32'h0, 32'h01020304}) begin bad++; $display("FAIL chk_w0 got=%0h want=0_01020304", g0); end
    total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL chk_status got=%0b%0b want=10", error, done); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL chk_cpu_hold got=%0b want=1", cpu_hold); end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_empty();
    test_oversize();
    test_gapped();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    total++; if (inv_bad !== 0) begin bad++; $display("FAIL hold_done_coupling got=%0d want=0", inv_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
